// File: rtl/walk_initiator_pkg.sv
// Shared encodings and constants for the LED-walker Wishbone initiator.
package walk_initiator_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned STATUS_W = 4;
  localparam logic        WALKER_ADDR = 1'b0;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WREQ = 3'd1;
  localparam logic [2:0] ST_WACK = 3'd2;
  localparam logic [2:0] ST_WAIT = 3'd3;
  localparam logic [2:0] ST_RREQ = 3'd4;
  localparam logic [2:0] ST_RACK = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE = ST_IDLE,
    S_WREQ = ST_WREQ,
    S_WACK = ST_WACK,
    S_WAIT = ST_WAIT,
    S_RREQ = ST_RREQ,
    S_RACK = ST_RACK
  } state_e;

  // Counter width able to hold max_val; never narrower than one bit.
  function automatic int unsigned ctr_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/walk_timer.sv
// Loadable saturating up/down counter with a registered terminal-count flag.
module walk_timer
  import walk_initiator_pkg::*;
#(
  parameter int unsigned MAX_VAL  = 15,
  parameter int unsigned TERM_VAL = 0,
  localparam int unsigned W       = ctr_width(MAX_VAL)
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  input  logic         up_i,
  output logic         term_o
);

  logic [W-1:0] count_q, count_d;
  logic         term_q;

  // Saturate at either end so the count never wraps.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i) begin
      if (up_i && (count_q != W'(MAX_VAL))) begin
        count_d = count_q + W'(1);
      end else if (!up_i && (count_q != '0)) begin
        count_d = count_q - W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
      term_q  <= (TERM_VAL == 0);
    end else begin
      count_q <= count_d;
      term_q  <= (count_d == W'(TERM_VAL));
    end
  end

  assign term_o = term_q;

endmodule

// File: rtl/walk_initiator.sv
// Wishbone pipelined master: one write starts a walk, then status reads are
// polled until the walker reports state zero, ending in done or err.
module walk_initiator
  import walk_initiator_pkg::*;
#(
  parameter int unsigned POLL_INTERVAL = 16,
  parameter int unsigned TIMEOUT       = 32
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_request,
  output logic                o_cyc,
  output logic                o_stb,
  output logic                o_we,
  output logic                o_addr,
  output logic [DATA_W-1:0]   o_data,
  input  logic                i_stall,
  input  logic                i_ack,
  input  logic [DATA_W-1:0]   i_data,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_err,
  output logic [STATUS_W-1:0] o_status
);

  localparam int unsigned POLL_W = ctr_width(POLL_INTERVAL - 1);
  localparam int unsigned TO_W   = ctr_width(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic                cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
  logic                busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic                pending_q, pending_d;
  logic [STATUS_W-1:0] status_q, status_d;
  logic                poll_load, poll_en, poll_term;
  logic                to_load, to_en, to_term;
  logic                abort;
  logic                unused_data;

  assign unused_data = ^i_data[DATA_W-1:STATUS_W];

  walk_timer #(.MAX_VAL(POLL_INTERVAL - 1), .TERM_VAL(0)) u_poll_timer (
    .clk_i      (i_clk),
    .reset_i    (i_reset),
    .load_i     (poll_load),
    .load_val_i (POLL_W'(POLL_INTERVAL - 1)),
    .en_i       (poll_en),
    .up_i       (1'b0),
    .term_o     (poll_term)
  );

  // Abort fires on the edge at which the count would reach TIMEOUT-1.
  walk_timer #(.MAX_VAL(TIMEOUT - 1), .TERM_VAL(TIMEOUT - 2)) u_timeout_timer (
    .clk_i      (i_clk),
    .reset_i    (i_reset),
    .load_i     (to_load),
    .load_val_i (TO_W'(0)),
    .en_i       (to_en),
    .up_i       (1'b1),
    .term_o     (to_term)
  );

  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    stb_d     = stb_q;
    we_d      = we_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    status_d  = status_q;
    pending_d = pending_q;
    poll_load = 1'b0;
    poll_en   = 1'b0;
    to_load   = 1'b0;
    to_en     = 1'b0;
    abort     = 1'b0;

    if (i_request && (state_q != S_IDLE)) pending_d = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (i_request || pending_q) begin
          state_d   = S_WREQ;
          cyc_d     = 1'b1;
          stb_d     = 1'b1;
          we_d      = 1'b1;
          pending_d = 1'b0;
          to_load   = 1'b1;
        end
      end
      // Read strobe is raised on the first RREQ cycle; write strobe already is.
      S_WREQ, S_RREQ: begin
        to_en = 1'b1;
        if (stb_q && !i_stall) begin
          state_d = (state_q == S_WREQ) ? S_WACK : S_RACK;
          stb_d   = 1'b0;
          we_d    = 1'b0;
        end else if (to_term) begin
          abort = 1'b1;
        end else begin
          cyc_d = 1'b1;
          stb_d = 1'b1;
          we_d  = (state_q == S_WREQ);
        end
      end
      S_WACK: begin
        to_en = 1'b1;
        if (i_ack) begin
          state_d   = S_WAIT;
          cyc_d     = 1'b0;
          poll_load = 1'b1;
        end else if (to_term) begin
          abort = 1'b1;
        end
      end
      S_WAIT: begin
        if (poll_term) begin
          state_d = S_RREQ;
          to_load = 1'b1;
        end else begin
          poll_en = 1'b1;
        end
      end
      S_RACK: begin
        to_en = 1'b1;
        if (i_ack) begin
          status_d = i_data[STATUS_W-1:0];
          cyc_d    = 1'b0;
          if (i_data[STATUS_W-1:0] == '0) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d   = S_WAIT;
            poll_load = 1'b1;
          end
        end else if (to_term) begin
          abort = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      state_d = S_IDLE;
      cyc_d   = 1'b0;
      stb_d   = 1'b0;
      we_d    = 1'b0;
      err_d   = 1'b1;
    end
  end

  assign busy_d = (state_d != S_IDLE);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= S_IDLE;
      cyc_q     <= 1'b0;
      stb_q     <= 1'b0;
      we_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      status_q  <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      stb_q     <= stb_d;
      we_q      <= we_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      status_q  <= status_d;
      pending_q <= pending_d;
    end
  end

  assign o_cyc    = cyc_q;
  assign o_stb    = stb_q;
  assign o_we     = we_q;
  assign o_busy   = busy_q;
  assign o_done   = done_q;
  assign o_err    = err_q;
  assign o_status = status_q;
  assign o_addr   = WALKER_ADDR;
  assign o_data   = '0;

endmodule

// File: doc/walk_initiator.md
# walk_initiator

Wishbone pipelined-mode bus master that drives the LED-walker responder. On a request pulse it issues one write that starts a walk. It then polls the responder's status word with periodic reads until the reported state returns to zero, and signals completion or timeout. It sits between a debounced button/trigger source and the walker's Wishbone slave port.

## Interface
- `POLL_INTERVAL`, default 16: idle cycles between the end of one status read and the next `o_stb`; must be ≥ 1.
- `TIMEOUT`, default 32: maximum cycles from `o_stb` rising to `i_ack` for one transaction; must be ≥ 2.
- `i_clk`, input, 1: sole clock, rising edge.
- `i_reset`, input, 1: synchronous, active-high reset.
- `i_request`, input, 1: single-cycle start request.
- `o_cyc`, `o_stb`, `o_we`, outputs, 1 each: Wishbone master strobes.
- `o_addr`, output, 1: always 0.
- `o_data`, output, 32: write data, always 32'h0.
- `i_stall`, `i_ack`, inputs, 1 each: slave stall and acknowledge.
- `i_data`, input, 32: read data; bits [3:0] are the walker state.
- `o_busy`, output, 1: high in any state other than IDLE.
- `o_done`, output, 1: one-cycle pulse when a walk is observed complete.
- `o_err`, output, 1: one-cycle pulse on timeout abort.
- `o_status`, output, 4: last captured `i_data[3:0]`.

## Operation
- States: IDLE, WREQ, WACK, WAIT, RREQ, RACK.
- **IDLE.** `i_request` or `pending` moves to WREQ; `pending` is cleared.
- **WREQ.** `o_cyc = o_stb = o_we = 1`. `o_stb && !i_stall` moves to WACK.
- **WACK.** `o_cyc = 1`, `o_stb = 0`. `i_ack` moves to WAIT and loads the poll counter with `POLL_INTERVAL - 1`.
- **WAIT.** `o_cyc = 0`. The counter decrements each cycle; reaching 0 moves to RREQ.
- **RREQ.** `o_cyc = o_stb = 1`, `o_we = 0`. Acceptance moves to RACK.
- **RACK.** On `i_ack`, capture `o_status <= i_data[3:0]`.
  - If `i_data[3:0] == 0`: pulse `o_done` and go to IDLE.
  - Otherwise: go to WAIT and reload the poll counter.
- **Timeout.** The counter loads 0 on entry to WREQ or RREQ and increments in WREQ, WACK, RREQ and RACK. When it reaches `TIMEOUT - 1` without `i_ack`: drop `o_cyc`/`o_stb`, pulse `o_err`, go to IDLE. `o_status` is unchanged.
- **Request while busy.** Sets `pending` (one deep; further requests are lost). `pending` is serviced immediately on return to IDLE, whether via done or via err.
- **Stray acks.** `i_ack` in IDLE, WREQ or WAIT is ignored.
- **Simultaneous acceptance.** `i_ack` in the same cycle as acceptance in WREQ/RREQ is ignored, because the ack is only sampled in WACK/RACK.
- **Timeout vs. ack.** If `i_ack` and the timeout condition occur in the same cycle, `i_ack` wins.
- **Widths and wrap.** Counter widths are `$clog2(max+1)`; the counters never wrap.

## Timing
- **Reset values.** `o_cyc = o_stb = o_we = 0`, `o_done = o_err = 0`, `o_busy = 0`, `o_status = 0`, `pending = 0`, state IDLE. Reset asserted mid-transaction drops `o_cyc` at that same edge with no err pulse.
- **Registered outputs.** All outputs are registered. `o_addr` and `o_data` are constants.
- **Request to strobe.** `i_request` at cycle N gives `o_stb` high at N+1.
- **Strobe hold.** `o_stb` and `o_we` hold stable while `i_stall` is high. `o_stb` drops the cycle after acceptance.
- **`o_cyc` span.** `o_cyc` stays high from `o_stb` rise until the cycle after `i_ack`.
- **Read spacing.** With zero-stall, one-cycle-ack slaves, consecutive read strobes are exactly `POLL_INTERVAL + 3` cycles apart.
- **Done latency.** `o_done` rises the cycle after the terminating `i_ack`, and `o_busy` falls in that same cycle.

## Structure
- **Shared package:** state encoding localparams (3-bit), the walker address constant (0), and the status field width (4).
- **Sub-module:** `walk_timer`, a loadable up/down counter with a terminal flag. It is instantiated twice, once for the poll interval and once for the timeout.
- **Remainder:** a single FSM plus output registers.

## Test plan
- **Single walk.** Reset, then `i_request`. A slave with no stall and one-cycle ack returns states 3, 7, 0 on successive reads.
  - One write, then three reads.
  - `o_status` reads 3, then 7, then 0.
  - `o_done` pulses once; `o_busy` falls in the same cycle.
- **Stall.** Slave holds `i_stall` for 4 cycles on the write. `o_stb` and `o_we` stay high and stable for 5 cycles, then the write is accepted.
- **Timeout.** Slave never acks the write.
  - `o_err` pulses at `o_stb` rise + 31 cycles; `o_cyc` drops.
  - The FSM returns to IDLE; `o_status` stays 0.
- **Pending request.** `i_request` twice during a walk. After `o_done`, exactly one new write starts on the next cycle; the second request is lost.
- **Reset mid-read.** Assert `i_reset` in RACK. Next cycle `o_cyc = 0`, `o_busy = 0`, `o_status = 0`; a late `i_ack` is ignored.
- **Ack/timeout collision.** `i_ack` arrives exactly at the timeout cycle with data 0. `o_done` pulses and `o_err` stays 0.
